seg_scan_rx: RTL and testbench

Receive side of the board's seven-segment display path. It samples a time-multiplexed, active-low segment bus (8 segment lines plus 8 digit enables) and decodes each scanned digit back to a 4-bit hex value. It rebuilds all eight positions and flags each completed frame. Typical uses are loop-back checking of the display driver and reading an external multiplexed display.

---
 rtl/seg_scan_rx_if.sv | 22 ++
 rtl/seg_scan_rx.sv | 162 ++++++++++++++++
 tb/tb_seg_scan_rx.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_rx_if.sv
// Seven-segment scan receive bus: active-low segment/anode inputs in,
// rebuilt display state and status strobes out.
interface seg_scan_rx_if;
   logic [7:0]  i_seg;
   logic [7:0]  i_an;
   logic [31:0] o_digits;
   logic [7:0]  o_dp;
   logic [7:0]  o_valid;
   logic        o_frame;
   logic        o_stale;
   logic        o_err;

   modport master (
      output i_seg, i_an,
      input  o_digits, o_dp, o_valid, o_frame, o_stale, o_err
   );

   modport slave (
      input  i_seg, i_an,
      output o_digits, o_dp, o_valid, o_frame, o_stale, o_err
   );
endinterface

// File: rtl/seg_scan_rx.sv
// seg_scan_rx: samples a multiplexed active-low seven-segment bus, waits
// for each scanned digit to settle, decodes it back to hex and rebuilds
// all eight display positions. It also flags completed frames, illegal
// anode patterns and a display that has stopped scanning.
module seg_scan_rx #(
   parameter int STABLE_CYC = 4,
   parameter int TIMEOUT    = 1000
) (
   input logic          clk,
   input logic          rst,
   seg_scan_rx_if.slave bus
);

   localparam logic [7:0]  CNT_MAX  = 8'(STABLE_CYC);
   localparam logic [7:0]  CNT_CAP  = 8'(STABLE_CYC - 1);
   localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);

   // {seg, an} travels as one 16-bit word through the synchroniser
   logic [15:0] sync1, sync2, s_prev;
   logic [7:0]  stab_cnt;
   logic [7:0]  mask;
   logic [15:0] wd_cnt;

   logic [7:0][3:0] digits;
   logic [7:0]      dp;
   logic [7:0]      valid;
   logic            frame_q, stale_q, err_q;

   logic [7:0] s_seg, s_an, an_hot, mask_nxt;
   logic       stable, cap, one_hot, blank;
   logic       cap_pos, cap_err, frame_hit, wd_hit;
   logic [4:0] glyph;

   // abcdefg (active-high) -> {hit, value}
   function automatic logic [4:0] decode(input logic [6:0] g);
      case (g)
         7'b1111110: decode = 5'h10;
         7'b0110000: decode = 5'h11;
         7'b1101101: decode = 5'h12;
         7'b1111001: decode = 5'h13;
         7'b0110011: decode = 5'h14;
         7'b1011011: decode = 5'h15;
         7'b1011111: decode = 5'h16;
         7'b1110000: decode = 5'h17;
         7'b1111111: decode = 5'h18;
         7'b1111011: decode = 5'h19;
         7'b1110111: decode = 5'h1A;
         7'b0011111: decode = 5'h1B;
         7'b1001110: decode = 5'h1C;
         7'b0111101: decode = 5'h1D;
         7'b1001111: decode = 5'h1E;
         7'b1000111: decode = 5'h1F;
         default:    decode = 5'h00;
      endcase
   endfunction

   assign s_seg   = sync2[15:8];
   assign s_an    = sync2[7:0];
   assign an_hot  = ~s_an;
   assign stable  = (sync2 == s_prev);
   // counter sits at STABLE_CYC-1 only once per dwell, so capture is single-shot
   assign cap     = stable && (stab_cnt == CNT_CAP);
   assign one_hot = (an_hot != 8'h00) && ((an_hot & (an_hot - 8'h01)) == 8'h00);
   assign blank   = (s_an == 8'hFF);
   assign cap_pos = cap && one_hot;
   assign cap_err = cap && !one_hot && !blank;
   assign mask_nxt  = mask | an_hot;
   assign frame_hit = cap_pos && (mask_nxt == 8'hFF);
   // a frame in the same cycle suppresses the timeout
   assign wd_hit  = !frame_hit && (wd_cnt == WD_LAST);
   assign glyph   = decode(~s_seg[7:1]);

   // two-flop synchroniser; resets to the blanking pattern
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= {bus.i_seg, bus.i_an};
         sync2 <= sync1;
      end
   end

   // dwell counter: restarts on any change, saturates once settled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_prev   <= '1;
         stab_cnt <= '0;
      end else begin
         s_prev <= sync2;
         if (!stable)
            stab_cnt <= '0;
         else if (stab_cnt != CNT_MAX)
            stab_cnt <= stab_cnt + 8'h01;
      end
   end

   // capture mask; the completing position starts the next frame empty
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         mask <= '0;
      else if (frame_hit)
         mask <= '0;
      else if (cap_pos)
         mask <= mask_nxt;
   end

   // single-cycle frame and error strobes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         frame_q <= frame_hit;
         err_q   <= cap_err;
      end
   end

   // stale watchdog: restarts on every frame, saturates otherwise
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt  <= '0;
         stale_q <= 1'b0;
      end else if (frame_hit) begin
         wd_cnt  <= '0;
         stale_q <= 1'b0;
      end else begin
         if (wd_cnt != 16'hFFFF)
            wd_cnt <= wd_cnt + 16'h0001;
         if (wd_hit)
            stale_q <= 1'b1;
      end
   end

   // per-position display state; a capture beats the timeout invalidate
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         digits <= '0;
         dp     <= '0;
         valid  <= '0;
      end else begin
         for (int n = 0; n < 8; n++) begin
            if (cap_pos && an_hot[n]) begin
               dp[n]    <= ~s_seg[0];
               valid[n] <= glyph[4];
               if (glyph[4])
                  digits[n] <= glyph[3:0];
            end else if (wd_hit) begin
               valid[n] <= 1'b0;
            end
         end
      end
   end

   assign bus.o_digits = digits;
   assign bus.o_dp     = dp;
   assign bus.o_valid  = valid;
   assign bus.o_frame  = frame_q;
   assign bus.o_stale  = stale_q;
   assign bus.o_err    = err_q;

endmodule

// File: tb/tb_seg_scan_rx.sv
// Directed bench for seg_scan_rx. dut1 uses the default timeout, dut2 a
// short timeout so the stale path is reachable; both see the same inputs.
module tb_seg_scan_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] seg = 8'hFF;
   logic [7:0] an  = 8'hFF;

   int checks   = 0;
   int failures = 0;
   int frames1  = 0;
   int errs1    = 0;
   logic [31:0] dig_at_frame = '0;
   logic [7:0]  val_at_frame = '0;
   logic [7:0]  val_before   = '0;
   logic [7:0]  prev_valid   = '0;

   always #5 clk = ~clk;

   seg_scan_rx_if bus1 ();
   seg_scan_rx_if bus2 ();

   assign bus1.i_seg = seg;
   assign bus1.i_an  = an;
   assign bus2.i_seg = seg;
   assign bus2.i_an  = an;

   seg_scan_rx #(.STABLE_CYC(4), .TIMEOUT(1000)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   seg_scan_rx #(.STABLE_CYC(4), .TIMEOUT(16))   dut2 (.clk(clk), .rst(rst), .bus(bus2));

   // active-low segment byte for a hex glyph
   function automatic logic [7:0] seg_of(input logic [3:0] v, input logic d);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'h7E;  4'h1: g = 7'h30;  4'h2: g = 7'h6D;  4'h3: g = 7'h79;
         4'h4: g = 7'h33;  4'h5: g = 7'h5B;  4'h6: g = 7'h5F;  4'h7: g = 7'h70;
         4'h8: g = 7'h7F;  4'h9: g = 7'h7B;  4'hA: g = 7'h77;  4'hB: g = 7'h1F;
         4'hC: g = 7'h4E;  4'hD: g = 7'h3D;  4'hE: g = 7'h4F;  default: g = 7'h47;
      endcase
      return ~{g, d};
   endfunction

   function automatic logic [7:0] an_of(input int p);
      logic [7:0] one;
      one = 8'h01;
      return ~(one << p);
   endfunction

   // drive a pair at a falling edge, then sample n cycles on falling edges
   task automatic hold(input logic [7:0] a, input logic [7:0] s, input int n);
      an  = a;
      seg = s;
      for (int i = 0; i < n; i++) begin
         prev_valid = bus1.o_valid;
         @(posedge clk);
         @(negedge clk);
         if (bus1.o_frame) begin
            frames1++;
            dig_at_frame = bus1.o_digits;
            val_at_frame = bus1.o_valid;
            val_before   = prev_valid;
         end
         if (bus1.o_err) errs1++;
      end
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      hold(8'hFF, 8'hFF, 2);
      rst = 1'b1;
      hold(8'hFF, 8'hFF, 2);
   endtask

   // positions 0..7 get glyphs 7,0,1,...,6
   task automatic scan();
      for (int p = 0; p < 8; p++)
         hold(an_of(p), seg_of(4'((p + 7) % 8), 1'b0), 6);
   endtask

   task automatic test_reset();
      @(negedge clk);
      hold(8'hFF, 8'hFF, 2);
      checks++;
      if ({bus1.o_digits, bus1.o_dp, bus1.o_valid} !== 48'h0) begin
         failures++;
         $display("FAIL reset_data got=%h exp=0", {bus1.o_digits, bus1.o_dp, bus1.o_valid});
      end
      checks++;
      if ({bus1.o_frame, bus1.o_stale, bus1.o_err} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=000", {bus1.o_frame, bus1.o_stale, bus1.o_err});
      end
      rst = 1'b1;
      hold(8'hFF, 8'hFF, 2);
   endtask

   task automatic test_single_digit();
      frames1 = 0;
      hold(8'hFB, 8'h0D, 6);
      checks++;
      if (bus1.o_valid !== 8'h00) begin
         failures++;
         $display("FAIL single_early got=%h exp=00", bus1.o_valid);
      end
      hold(8'hFB, 8'h0D, 1);
      checks++;
      if (bus1.o_digits[11:8] !== 4'h3) begin
         failures++;
         $display("FAIL single_digit got=%h exp=3", bus1.o_digits[11:8]);
      end
      checks++;
      if (bus1.o_valid !== 8'h04 || bus1.o_dp !== 8'h00) begin
         failures++;
         $display("FAIL single_valid_dp got=%h/%h exp=04/00", bus1.o_valid, bus1.o_dp);
      end
      hold(8'hFB, 8'h0D, 1);
      hold(8'hFF, 8'hFF, 4);
      checks++;
      if (frames1 !== 0) begin
         failures++;
         $display("FAIL single_noframe got=%0d exp=0", frames1);
      end
   endtask

   task automatic test_full_scan();
      frames1 = 0;
      scan();
      hold(8'hFF, 8'hFF, 8);
      checks++;
      if (frames1 !== 1) begin
         failures++;
         $display("FAIL scan_frames got=%0d exp=1", frames1);
      end
      checks++;
      if (dig_at_frame !== 32'h65432107 || val_at_frame !== 8'hFF) begin
         failures++;
         $display("FAIL scan_at_frame got=%h/%h exp=65432107/ff", dig_at_frame, val_at_frame);
      end
      checks++;
      if (val_before !== 8'h7F) begin
         failures++;
         $display("FAIL scan_frame_timing valid_before=%h exp=7f", val_before);
      end
      checks++;
      if (bus1.o_digits !== 32'h65432107 || bus1.o_valid !== 8'hFF) begin
         failures++;
         $display("FAIL scan_final got=%h/%h exp=65432107/ff", bus1.o_digits, bus1.o_valid);
      end
   endtask

   task automatic test_glitch();
      apply_reset();
      hold(8'hFE, seg_of(4'h5, 1'b0), 3);
      hold(8'hFF, 8'hFF, 10);
      checks++;
      if (bus1.o_valid !== 8'h00 || bus1.o_digits !== 32'h0) begin
         failures++;
         $display("FAIL glitch got=%h/%h exp=00/00000000", bus1.o_valid, bus1.o_digits);
      end
   endtask

   task automatic test_illegal();
      errs1 = 0;
      hold(8'hFD, seg_of(4'h9, 1'b1), 6);
      hold(8'hFF, 8'hFF, 2);
      checks++;
      if (bus1.o_digits !== 32'h90 || bus1.o_valid !== 8'h02 || bus1.o_dp !== 8'h02) begin
         failures++;
         $display("FAIL illegal_setup got=%h/%h/%h exp=00000090/02/02", bus1.o_digits, bus1.o_valid, bus1.o_dp);
      end
      hold(8'hF3, seg_of(4'h9, 1'b1), 8);
      hold(8'hFF, 8'hFF, 4);
      checks++;
      if (errs1 !== 1) begin
         failures++;
         $display("FAIL illegal_an_err got=%0d exp=1", errs1);
      end
      checks++;
      if (bus1.o_digits !== 32'h90 || bus1.o_valid !== 8'h02 || bus1.o_dp !== 8'h02) begin
         failures++;
         $display("FAIL illegal_an_state got=%h/%h/%h exp=00000090/02/02", bus1.o_digits, bus1.o_valid, bus1.o_dp);
      end
      hold(8'hFD, 8'h55, 6);
      hold(8'hFF, 8'hFF, 4);
      checks++;
      if (bus1.o_valid !== 8'h00 || bus1.o_digits[7:4] !== 4'h9 || bus1.o_dp !== 8'h00) begin
         failures++;
         $display("FAIL illegal_glyph got=%h/%h/%h exp=00/9/00", bus1.o_valid, bus1.o_digits[7:4], bus1.o_dp);
      end
      checks++;
      if (errs1 !== 1) begin
         failures++;
         $display("FAIL illegal_glyph_err got=%0d exp=1", errs1);
      end
   endtask

   task automatic test_stale();
      logic found;
      apply_reset();
      scan();
      checks++;
      if (bus2.o_stale !== 1'b1) begin
         failures++;
         $display("FAIL stale_before_frame got=%b exp=1", bus2.o_stale);
      end
      an = 8'hFF; seg = 8'hFF;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(posedge clk); @(negedge clk);
         if (bus2.o_frame) found = 1'b1;
      end
      checks++;
      if (!found || bus2.o_stale !== 1'b0) begin
         failures++;
         $display("FAIL stale_frame1 found=%b stale=%b exp=1/0", found, bus2.o_stale);
      end
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); @(negedge clk);
         if (n == 15) begin
            checks++;
            if (bus2.o_stale !== 1'b0) begin
               failures++;
               $display("FAIL stale_early got=%b exp=0", bus2.o_stale);
            end
         end
         if (n == 16) begin
            checks++;
            if (bus2.o_stale !== 1'b1 || bus2.o_valid !== 8'h00 || bus2.o_digits !== 32'h65432107) begin
               failures++;
               $display("FAIL stale_hit got=%b/%h/%h exp=1/00/65432107", bus2.o_stale, bus2.o_valid, bus2.o_digits);
            end
         end
      end
      scan();
      checks++;
      if (bus2.o_stale !== 1'b1) begin
         failures++;
         $display("FAIL stale_hold got=%b exp=1", bus2.o_stale);
      end
      an = 8'hFF; seg = 8'hFF;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(posedge clk); @(negedge clk);
         if (bus2.o_frame) found = 1'b1;
      end
      checks++;
      if (!found || bus2.o_stale !== 1'b0) begin
         failures++;
         $display("FAIL stale_recover found=%b stale=%b exp=1/0", found, bus2.o_stale);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      frames1 = 0;
      for (int p = 0; p < 4; p++) hold(an_of(p), seg_of(4'(p + 8), 1'b0), 6);
      hold(8'hFF, 8'hFF, 3);
      checks++;
      if (bus1.o_valid !== 8'h0F || bus1.o_digits !== 32'h0000BA98) begin
         failures++;
         $display("FAIL arst_pre got=%h/%h exp=0f/0000ba98", bus1.o_valid, bus1.o_digits);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({bus1.o_digits, bus1.o_dp, bus1.o_valid, bus1.o_frame, bus1.o_stale, bus1.o_err} !== 51'h0) begin
         failures++;
         $display("FAIL arst_immediate got=%h/%h/%h exp=0/0/0", bus1.o_digits, bus1.o_dp, bus1.o_valid);
      end
      @(negedge clk);
      rst = 1'b1;
      hold(8'hFF, 8'hFF, 2);
      for (int p = 4; p < 8; p++) hold(an_of(p), seg_of(4'(p), 1'b0), 6);
      hold(8'hFF, 8'hFF, 8);
      checks++;
      if (frames1 !== 0 || bus1.o_valid !== 8'hF0) begin
         failures++;
         $display("FAIL arst_half got=%0d/%h exp=0/f0", frames1, bus1.o_valid);
      end
      for (int p = 0; p < 4; p++) hold(an_of(p), seg_of(4'(p + 8), 1'b0), 6);
      hold(8'hFF, 8'hFF, 8);
      checks++;
      if (frames1 !== 1 || bus1.o_digits !== 32'h7654BA98) begin
         failures++;
         $display("FAIL arst_full got=%0d/%h exp=1/7654ba98", frames1, bus1.o_digits);
      end
   endtask

   initial begin
      test_reset();
      test_single_digit();
      test_full_scan();
      test_glitch();
      test_illegal();
      test_stale();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "time limit");
   end

endmodule
